// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-256 constants, FSM state type and word helpers
package aes_pkg;
    localparam int AES256_NR = 14;
    localparam logic [6:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box (FIPS-197 table)
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign y = SBOX[a];
endmodule

// File: rtl/aes256_inv_key_sched.sv
// aes256_inv_key_sched: regenerates AES-256 round keys 14..0 backwards from w[52..59],
// one round per STEP, streamed over a valid/ready port.
module aes256_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] keyIn,
    output logic         busy,
    output logic         rkValid,
    input  logic         rkReady,
    output logic [127:0] rkOut,
    output logic [3:0]   rkIdx,
    output logic         done
);
    state_t state, state_nx;
    logic [255:0] win;
    logic [127:0] new_rk;
    logic [31:0] w3, w4, w5, w6, w7, sub_in, sub_out;
    logic first;
    assign {w3, w4, w5, w6, w7} = win[159:0];
    assign first = rkIdx == 4'(AES256_NR);
    // Odd current round means the new round q-1 is even: RotWord and rcon apply.
    assign sub_in = rkIdx[0] ? rot_word(w3) : w3;
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*i +: 8]), .y(sub_out[8*i +: 8]));
    end
    assign new_rk = {w4 ^ sub_out ^ (rkIdx[0] ? {RCON[rkIdx[3:1]], 24'h0} : 32'h0),
                     w5 ^ w4, w6 ^ w5, w7 ^ w6};
    assign busy = state != IDLE;
    assign rkValid = state == EMIT;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? EMIT : IDLE;
            EMIT:    state_nx = !rkReady ? EMIT : first ? EMIT : (rkIdx == 4'd0) ? DONE : STEP;
            STEP:    state_nx = EMIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win   <= '0;
            rkOut <= '0;
            rkIdx <= '0;
        end else if (state == IDLE && start) begin
            win   <= keyIn;
            rkOut <= keyIn[127:0];
            rkIdx <= 4'(AES256_NR);
        end else if (rkValid && rkReady && first) begin
            rkOut <= win[255:128];
            rkIdx <= rkIdx - 4'd1;
        end else if (state == STEP) begin
            win   <= {new_rk, win[255:128]};
            rkOut <= new_rk;
            rkIdx <= rkIdx - 4'd1;
        end
    end
endmodule

// File: doc/aes256_inv_key_sched.md
# aes256_inv_key_sched

Reverse-order AES-256 round-key generator for the decryption datapath. It takes the last two round keys (expanded words w[52..59]) produced by the forward key expansion. It regenerates the schedule backwards on the fly and delivers the 15 round keys, round 14 down to round 0, over a valid/ready stream. This avoids storing all 60 words.

## Interface
- No parameters; AES-256 only (Nk=8, Nr=14).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset rst, asynchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- keyIn  in  256  {w52,w53,...,w59}, w52 in [255:224]; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- rkValid  out  1  rkOut/rkIdx valid.
- rkReady  in  1  consumer accepts when rkValid&&rkReady at a rising edge.
- rkOut  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- rkIdx  out  4  round number r of rkOut (14..0).
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- Window register win[255:0] holds eight words w[4q..4q+7], which are rounds q and q+1.
- Backward recurrence for new round q-1, with base b=4(q-1):
  - w[b] = w[b+8] ^ Sub(Rot(w[b+7])) ^ rcon[(q-1)/2] if q-1 is even.
  - w[b] = w[b+8] ^ Sub(w[b+7]) if q-1 is odd.
  - w[b+j] = w[b+8+j] ^ w[b+7+j], for j=1..3.
- All four words depend only on the window, so one round key is produced per STEP cycle. It needs one 4-byte SubWord.
- rcon[0..6] = 01,02,04,08,10,20,40, in the MSB byte. For example, the round-12 step uses 40000000 and round 0 uses 01000000.
- After a step, win <= {newwords, win[255:128]}.
- FSM states:
  - IDLE: start -> win<=keyIn, rkOut<=keyIn[127:0], rkIdx<=14, go to EMIT.
  - EMIT: rkValid=1 and rkOut is held stable. On accept:
    - if rkIdx==14: rkOut<=win[255:128], rkIdx<=13, stay in EMIT.
    - if rkIdx==0: go to DONE.
    - else: go to STEP.
  - STEP: compute round rkIdx-1, load rkOut, shift win, decrement rkIdx, go to EMIT.
  - DONE: done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE; keyIn is not re-sampled mid-run.
- rkValid never drops without an accept, and rkOut does not change while rkValid && !rkReady.

## Timing
- Reset values: busy=0, rkValid=0, rkOut=0, rkIdx=0, done=0; FSM in IDLE; win=0.
- start accepted at edge N: rkValid=1 with round 14 from cycle N+1.
- Round 14 accepted at edge M: round 13 is valid at M+1, with no bubble.
- Round r (13..1) accepted at edge M: round r-1 is valid at M+2, with one STEP bubble.
- Minimum from start to done pulse, with rkReady tied high, is 30 cycles: 15 emits, 13 steps, 1 load, 1 done.
- rst asserted mid-run: everything returns to reset values immediately, and any partial key is discarded.
- Back-pressure of arbitrary length on any round holds outputs stable with no loss.

## Structure
- Shared package aes_pkg:
  - rcon table (7 entries).
  - AES256_NR=14.
  - FSM state enum {IDLE, EMIT, STEP, DONE}.
  - word-rotate helper.
- Sub-module aes_sbox: combinational 8-bit forward S-box, FIPS-197 table. Instantiate it four times for SubWord.
- The S-box is the forward table; the inverse S-box is not used.

## Test plan
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - Stimulus: keyIn = words 52..59 of its expansion (computed by bench model), rkReady=1.
  - Required: 15 keys in order 14..0; round 1 = 1f352c07 3b6108d7 2d9810a3 0914dff4; round 0 = 603deb10 15ca71be 2b73aef0 857d7781; done 30 cycles after start.
- Random keys (≥200): forward-expand in the bench, feed w52..59, and compare all 15 rounds and rkIdx against the model.
- Random rkReady back-pressure (30% high) -> identical key sequence; rkOut stable while stalled; no duplicate or missing rkIdx.
- start re-pulsed during EMIT/STEP with a different keyIn -> ignored; output sequence unchanged.
- rst deasserted-to-asserted while at rkIdx=7, then released and restarted -> all outputs 0 during reset; the new run starts at rkIdx=14 with correct keys.
- All-zero keyIn -> round 0 matches the bench model; rcon applied at even rounds only, e.g. round 12 uses 40000000.
